bsg_reg_bank_load_ctrl: RTL and testbench
=========================================

Name: bsg_reg_bank_load_ctrl

Overview:
Sequences loading of a bank of els_p enable-gated registers, such as convolution weight or threshold registers, from a single valid/ready word stream.
- Each accepted word is broadcast on data_o, and exactly one one-hot enable strobe is raised on en_o for that word.
- Register slots are filled in ascending index order, starting at 0.
- Sits between the host/config stream and the register bank of the recognition datapath.
- Signals completion with a one-cycle done pulse.

Parameters:
width_p, -1 (must be set), data word width.
els_p, -1 (must be set, >=1), number of registers in the bank.
lg_els_p, `BSG_SAFE_CLOG2(els_p+1), width of the length and index fields.

Ports:
clock_i  in  1  clock.
reset_i  in  1  asynchronous active-high reset.
start_i  in  1  request a load sequence; sampled only in IDLE.
len_i  in  lg_els_p  number of words to load; captured with start_i. Legal range 0..els_p; values above els_p are clamped to els_p.
abort_i  in  1  terminate the current sequence.
v_i  in  1  input word valid.
data_i  in  width_p  input word.
ready_o  out  1  controller accepts a word this cycle.
en_o  out  els_p  one-hot enable to the bank registers.
data_o  out  width_p  word to the bank registers.
busy_o  out  1  high in LOAD or DONE.
done_o  out  1  one-cycle completion pulse.
count_o  out  lg_els_p  words loaded in the current or last sequence.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clock):
  - State = IDLE; idx, len_r and count_o = 0.
  - ready_o, en_o, done_o and busy_o = 0.
  - data_o = data_i (purely combinational pass-through, no register).
- States: IDLE, LOAD, DONE.
- IDLE:
  - ready_o = 0.
  - On start_i: capture len_r = min(len_i, els_p) and clear idx and count.
  - If the clamped length is 0, go to DONE; otherwise go to LOAD.
- LOAD:
  - ready_o = ~abort_i.
  - Accept occurs when v_i & ready_o. On accept, in the same cycle:
    - en_o[idx] = 1 and all other en_o bits = 0;
    - next-cycle idx = idx+1 and count = count+1.
  - With no accept, en_o = 0 and idx holds.
  - Accept of the word with idx == len_r-1 transitions to DONE.
- Abort:
  - abort_i in LOAD has priority over an accept that cycle: no en_o bit, no count increment.
  - Next state is IDLE; done_o is not pulsed; count_o keeps the partial count.
  - abort_i outside LOAD is ignored.
- DONE:
  - done_o = 1 for exactly one cycle, then IDLE.
  - ready_o = 0; en_o = 0.
- start_i is ignored in LOAD and DONE, with no queuing. A start_i in the same cycle as done_o is dropped.
- Latency:
  - Enable strobe: 0 cycles from accept (combinational from v_i).
  - done_o: 1 cycle after the final accept.
  - Back-to-back loads: minimum 2 idle-free cycles between sequences (DONE then IDLE).
- Invariants:
  - en_o is never more than one-hot.
  - en_o is never nonzero outside LOAD.
  - idx never reaches els_p.
- Reset asserted mid-sequence: immediate return to reset state. Registers already loaded in the bank are unaffected by this block.
- v_i may be asserted while ready_o = 0 with no effect. data_i need not be held once accepted.

Test Plan:
- Reset with els_p=4, width_p=8; start_i with len_i=4; stream 0x11, 0x22, 0x33, 0x44 back-to-back:
  - en_o = 0001, 0010, 0100, 1000 on consecutive cycles with data_o matching each word;
  - done_o pulses on the next cycle; count_o = 4.
- len_i=2 with v_i gapped (valid, idle, idle, valid) -> en_o pulses only on valid cycles (0001, then 0010); done_o one cycle after the second; count_o = 2.
- len_i=0 -> no en_o activity, ready_o stays 0, done_o pulses 1 cycle after start.
- len_i=7 with els_p=4 -> clamped: exactly 4 accepts, then done_o; en_o never exceeds bit 3.
- Abort:
  - abort_i asserted in the same cycle as the 3rd valid word -> ready_o = 0 that cycle, en_o = 0, no done_o;
  - returns to IDLE with count_o = 2;
  - a new start loads from idx 0.
- Reset asserted asynchronously mid-LOAD between clock edges -> busy_o, ready_o and en_o drop immediately, count_o = 0; start_i after release begins a fresh sequence.
- start_i pulsed during LOAD and coincident with done_o -> both ignored; state returns to IDLE and stays there.

Source files
------------

// File: rtl/bsg_reg_bank_load_ctrl.sv
// Streams words from a valid/ready source into a bank of enable-gated registers,
// raising one one-hot enable per accepted word and pulsing done at the end.
module bsg_reg_bank_load_ctrl #(
    parameter int width_p  = -1,
    parameter int els_p    = -1,
    parameter int lg_els_p = (els_p < 1) ? 1 : $clog2(els_p + 1)
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [lg_els_p-1:0] len_i,
    input  logic                abort_i,
    input  logic                v_i,
    input  logic [width_p-1:0]  data_i,
    output logic                ready_o,
    output logic [els_p-1:0]    en_o,
    output logic [width_p-1:0]  data_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [lg_els_p-1:0] count_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [lg_els_p-1:0] els_lp = lg_els_p'(els_p);

    logic [1:0]          state;
    logic [lg_els_p-1:0] idx;
    logic [lg_els_p-1:0] len_r;
    logic [lg_els_p-1:0] count;
    logic [lg_els_p-1:0] len_clamp;
    logic                accept;
    logic                last;

    assign len_clamp = (len_i > els_lp) ? els_lp : len_i;
    assign ready_o   = (state == LOAD) && !abort_i;
    assign accept    = ready_o && v_i;
    assign last      = (idx == (len_r - lg_els_p'(1)));
    assign data_o    = data_i;
    assign busy_o    = (state == LOAD) || (state == DONE);
    assign done_o    = (state == DONE);
    assign count_o   = count;

    always_comb begin
        en_o = '0;
        for (int i = 0; i < els_p; i++) begin
            en_o[i] = accept && (idx == lg_els_p'(i));
        end
    end

    // idx is cleared on the final accept so it never reaches els_p.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            idx   <= '0;
            len_r <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_r <= len_clamp;
                        idx   <= '0;
                        count <= '0;
                        state <= (len_clamp == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (v_i) begin
                        count <= count + lg_els_p'(1);
                        if (last) begin
                            idx   <= '0;
                            state <= DONE;
                        end else begin
                            idx <= idx + lg_els_p'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_reg_bank_load_ctrl.sv
// Directed bench for bsg_reg_bank_load_ctrl with els_p=4, width_p=8.
module tb_bsg_reg_bank_load_ctrl;

    localparam int width_p  = 8;
    localparam int els_p    = 4;
    localparam int lg_els_p = 3;

    logic                clock_i = 1'b0;
    logic                reset_i = 1'b0;
    logic                start_i = 1'b0;
    logic [lg_els_p-1:0] len_i   = '0;
    logic                abort_i = 1'b0;
    logic                v_i     = 1'b0;
    logic [width_p-1:0]  data_i  = '0;
    logic                ready_o;
    logic [els_p-1:0]    en_o;
    logic [width_p-1:0]  data_o;
    logic                busy_o;
    logic                done_o;
    logic [lg_els_p-1:0] count_o;

    int n_checks = 0;
    int n_pass   = 0;

    bsg_reg_bank_load_ctrl #(.width_p(width_p), .els_p(els_p)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .len_i(len_i),
        .abort_i(abort_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .en_o(en_o), .data_o(data_o), .busy_o(busy_o), .done_o(done_o),
        .count_o(count_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Drive one LOAD-cycle word, check the strobe mid-cycle, then advance.
    task automatic stream_word(input string tag, input logic v, input logic [7:0] d,
                               input logic [3:0] exp_en);
        v_i    = v;
        data_i = d;
        #2;
        chk({tag, "_en"}, 32'(en_o), 32'(exp_en));
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        if (v) chk({tag, "_data"}, 32'(data_o), 32'(d));
        tick();
    endtask

    task automatic start_load(input logic [2:0] len);
        start_i = 1'b1;
        len_i   = len;
        #2;
        chk("idle_ready", 32'(ready_o), 32'd0);
        chk("idle_en", 32'(en_o), 32'd0);
        tick();
        start_i = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic [2:0] cnt);
        v_i = 1'b0;
        #2;
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        chk({tag, "_en0"}, 32'(en_o), 32'd0);
        chk({tag, "_rdy0"}, 32'(ready_o), 32'd0);
        chk({tag, "_count"}, 32'(count_o), 32'(cnt));
        tick();
        #2;
        chk({tag, "_done_off"}, 32'(done_o), 32'd0);
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        // reset state and pass-through
        reset_i = 1'b1;
        data_i  = 8'hA5;
        #3;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_en", 32'(en_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'hA5);
        tick();
        reset_i = 1'b0;
        tick();

        // full back-to-back load
        start_load(3'd4);
        stream_word("b2b0", 1'b1, 8'h11, 4'b0001);
        stream_word("b2b1", 1'b1, 8'h22, 4'b0010);
        stream_word("b2b2", 1'b1, 8'h33, 4'b0100);
        stream_word("b2b3", 1'b1, 8'h44, 4'b1000);
        expect_done("b2b", 3'd4);

        // gapped valid
        start_load(3'd2);
        stream_word("gap0", 1'b1, 8'h55, 4'b0001);
        stream_word("gap1", 1'b0, 8'h00, 4'b0000);
        stream_word("gap2", 1'b0, 8'h00, 4'b0000);
        stream_word("gap3", 1'b1, 8'h66, 4'b0010);
        expect_done("gap", 3'd2);

        // zero length: straight to DONE, v_i ignored
        v_i = 1'b1;
        start_load(3'd0);
        #2;
        chk("zero_en", 32'(en_o), 32'd0);
        chk("zero_ready", 32'(ready_o), 32'd0);
        #1;
        expect_done("zero", 3'd0);

        // over-length clamps to els_p; v_i stays high into DONE
        start_load(3'd7);
        stream_word("clmp0", 1'b1, 8'hA0, 4'b0001);
        stream_word("clmp1", 1'b1, 8'hA1, 4'b0010);
        stream_word("clmp2", 1'b1, 8'hA2, 4'b0100);
        stream_word("clmp3", 1'b1, 8'hA3, 4'b1000);
        v_i = 1'b1;
        #2;
        chk("clmp_done", 32'(done_o), 32'd1);
        chk("clmp_en_done", 32'(en_o), 32'd0);
        chk("clmp_count", 32'(count_o), 32'd4);
        tick();
        v_i = 1'b0;

        // abort with the 3rd valid word
        start_load(3'd4);
        stream_word("abt0", 1'b1, 8'hB0, 4'b0001);
        stream_word("abt1", 1'b1, 8'hB1, 4'b0010);
        v_i     = 1'b1;
        abort_i = 1'b1;
        #2;
        chk("abt_ready", 32'(ready_o), 32'd0);
        chk("abt_en", 32'(en_o), 32'd0);
        tick();
        v_i     = 1'b0;
        abort_i = 1'b0;
        #2;
        chk("abt_busy", 32'(busy_o), 32'd0);
        chk("abt_done", 32'(done_o), 32'd0);
        chk("abt_count", 32'(count_o), 32'd2);
        #1;
        start_load(3'd1);
        stream_word("abt_new", 1'b1, 8'hC0, 4'b0001);
        expect_done("abt_new", 3'd1);

        // asynchronous reset in the middle of a load
        start_load(3'd4);
        stream_word("ar0", 1'b1, 8'h77, 4'b0001);
        v_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        chk("ar_busy", 32'(busy_o), 32'd0);
        chk("ar_ready", 32'(ready_o), 32'd0);
        chk("ar_en", 32'(en_o), 32'd0);
        chk("ar_count", 32'(count_o), 32'd0);
        tick();
        reset_i = 1'b0;
        v_i     = 1'b0;
        start_load(3'd2);
        stream_word("ar_new0", 1'b1, 8'h78, 4'b0001);
        stream_word("ar_new1", 1'b1, 8'h79, 4'b0010);
        expect_done("ar_new", 3'd2);

        // start_i held through LOAD and DONE is ignored
        start_load(3'd2);
        start_i = 1'b1;
        len_i   = 3'd3;
        stream_word("sig0", 1'b1, 8'hD0, 4'b0001);
        stream_word("sig1", 1'b1, 8'hD1, 4'b0010);
        v_i = 1'b0;
        #2;
        chk("sig_done", 32'(done_o), 32'd1);
        tick();
        start_i = 1'b0;
        #2;
        chk("sig_idle0", 32'(busy_o), 32'd0);
        tick();
        #2;
        chk("sig_idle1", 32'(busy_o), 32'd0);
        chk("sig_count", 32'(count_o), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
